round_robin_arb_quantum: RTL

Parametrised N-way round-robin arbiter with a per-grant time quantum. A requester keeps the grant while it holds its request, for at most QUANTUM consecutive cycles. When the quantum expires and another requester is pending, the grant rotates to the next pending requester. The block sits in front of shared resources (bus, memory port, FIFO write side), where a single requester must not be able to hold the resource indefinitely.

---
 rtl/round_robin_arb_quantum_if.sv | 30 +++
 rtl/round_robin_arb_quantum.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/round_robin_arb_quantum_if.sv
// Request/grant bundle between requesters and the quantum round-robin arbiter.
// The master side drives the request vector; the slave side (the arbiter)
// returns the registered grant, its index, a valid flag and the expiry pulse.
interface round_robin_arb_quantum_if #(
  parameter int N = 4
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             expired;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_idx,
    input  expired
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_idx,
    output expired
  );
endinterface

// File: rtl/round_robin_arb_quantum.sv
// N-way round-robin arbiter with a per-grant time quantum.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no requester granted; next grant searched after ptr_q
//   ST_GRANT | requester grant_idx_q holds the resource, cnt_q cycles so far
//
// A holder keeps the grant while it requests, for at most QUANTUM cycles in a
// row. When the quantum runs out and someone else is waiting, the grant moves
// to the next waiting requester on the same edge and expired pulses for one
// cycle. A lone holder whose quantum runs out simply starts a fresh quantum.
// All outputs come straight from flops; req only reaches the next-state logic.
module round_robin_arb_quantum #(
  parameter int N       = 4,
  parameter int QUANTUM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  round_robin_arb_quantum_if.slave   arb
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(QUANTUM + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM);
  localparam logic [N-1:0]     ONE_HOT = N'(1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           state_q,   state_d;
  logic [N-1:0]     grant_q,   grant_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [IDX_W-1:0] ptr_q,     ptr_d;
  logic             expired_q, expired_d;

  logic [N-1:0]     others;
  logic [IDX_W-1:0] next_after_ptr;
  logic [IDX_W-1:0] next_after_holder;

  // First requester strictly after x, wrapping around; x itself is tried last.
  function automatic logic [IDX_W-1:0] rr_next(input logic [N-1:0]     r,
                                               input logic [IDX_W-1:0] x);
    logic [IDX_W-1:0] sel;
    logic             hit;
    int               j;
    sel = '0;
    hit = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(x) + k) % N;
      if (!hit && r[IDX_W'(j)]) begin
        sel = IDX_W'(j);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  assign others            = arb.req & ~grant_q;
  assign next_after_ptr    = rr_next(arb.req, ptr_q);
  assign next_after_holder = rr_next(arb.req, idx_q);

  // Next-state decision from the registered state and the sampled request vector.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    expired_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|arb.req) begin
          state_d = ST_GRANT;
          idx_d   = next_after_ptr;
          grant_d = ONE_HOT << next_after_ptr;
          cnt_d   = CNT_ONE;
        end
      end

      ST_GRANT: begin
        if (arb.req[idx_q]) begin
          if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else if (|others) begin
            // Quantum used up while someone else waits: forced rotation.
            idx_d     = next_after_holder;
            grant_d   = ONE_HOT << next_after_holder;
            cnt_d     = CNT_ONE;
            ptr_d     = idx_q;
            expired_d = 1'b1;
          end else begin
            // Nobody else wants it; the holder starts a fresh quantum.
            cnt_d = CNT_ONE;
          end
        end else begin
          // Holder released; a release never counts as an expiry.
          ptr_d = idx_q;
          if (|arb.req) begin
            idx_d   = next_after_holder;
            grant_d = ONE_HOT << next_after_holder;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
            grant_d = '0;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears outputs without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= PTR_RST;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      expired_q <= expired_d;
    end
  end

  assign arb.grant       = grant_q;
  assign arb.grant_valid = (state_q == ST_GRANT);
  assign arb.grant_idx   = idx_q;
  assign arb.expired     = expired_q;

endmodule
